// File: rtl/pl_hazard_ctrl.sv
// Pipeline hazard and exception controller for the 5-stage MIPS pipeline.
// Tracks the destinations of the instructions in EX and MEM, stalls ID on
// read-after-write hazards, flushes IF/ID on taken branches and jumps, and
// runs a drain-then-halt sequence when ID holds an undefined instruction.
module pl_hazard_ctrl #(
    parameter int FORWARDING   = 1,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      id_pc,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_dst,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_jump,
    input  logic             id_undefined_instr,
    input  logic             ex_branch_taken,
    output logic             id_nop,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             halted,
    output logic [31:0]      epc,
    output logic [CNT_W-1:0] stall_count
);

    // The drain counter holds DRAIN_CYCLES-1 down to 0.
    localparam int DW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);
    localparam bit FWD = (FORWARDING != 0);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t          state;
    logic [DW-1:0]   drain_cnt;

    logic [4:0]      ex_dst;
    logic            ex_wr;
    logic            ex_mr;
    logic [4:0]      mem_dst;
    logic            mem_wr;

    logic            ex_src;
    logic            mem_src;
    logic            reads_rs;
    logic            reads_rt;
    logic            haz;
    logic            take_trap;
    logic            take_stall;

    // Hazard detection: with forwarding only a load in EX can stall; without
    // it any pending register write in EX or MEM blocks the reader. Register 0
    // is excluded on the reader side so it never matches.
    always_comb begin
        ex_src   = ex_wr & (ex_mr | ~FWD);
        mem_src  = mem_wr & ~FWD;
        reads_rs = id_uses_rs & (id_rs != 5'd0);
        reads_rt = id_uses_rt & (id_rt != 5'd0);
        haz = (reads_rs & ((ex_src & (id_rs == ex_dst)) | (mem_src & (id_rs == mem_dst))))
            | (reads_rt & ((ex_src & (id_rt == ex_dst)) | (mem_src & (id_rt == mem_dst))));
    end

    // Pipeline control outputs; a taken branch in EX outranks anything in ID
    // because the ID instruction is on the wrong path.
    always_comb begin
        id_nop     = 1'b0;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        halted     = 1'b0;
        take_trap  = 1'b0;
        take_stall = 1'b0;
        case (state)
            RUN: begin
                if (ex_branch_taken) begin
                    ifid_flush = 1'b1;
                    id_nop     = 1'b1;
                end else if (id_undefined_instr) begin
                    take_trap  = 1'b1;
                    id_nop     = 1'b1;
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                end else if (haz) begin
                    take_stall = 1'b1;
                    id_nop     = 1'b1;
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                end else if (id_jump) begin
                    ifid_flush = 1'b1;
                end
            end
            DRAIN: begin
                id_nop     = 1'b1;
                pc_write   = 1'b0;
                ifid_write = 1'b0;
            end
            HALTED: begin
                halted     = 1'b1;
                id_nop     = 1'b1;
                pc_write   = 1'b0;
                ifid_write = 1'b0;
            end
            default: begin
                id_nop     = 1'b1;
                pc_write   = 1'b0;
                ifid_write = 1'b0;
            end
        endcase
    end

    // Shadow of the EX and MEM stage destinations; a bubble clears the EX copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_dst  <= 5'd0;
            ex_wr   <= 1'b0;
            ex_mr   <= 1'b0;
            mem_dst <= 5'd0;
            mem_wr  <= 1'b0;
        end else begin
            ex_dst  <= id_nop ? 5'd0 : id_dst;
            ex_wr   <= id_nop ? 1'b0 : id_reg_write;
            ex_mr   <= id_nop ? 1'b0 : id_mem_read;
            mem_dst <= ex_dst;
            mem_wr  <= ex_wr;
        end
    end

    // Trap sequencing, exception PC capture and saturating stall counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            drain_cnt   <= '0;
            epc         <= 32'd0;
            stall_count <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (take_trap) begin
                        epc       <= id_pc;
                        drain_cnt <= DRAIN_INIT;
                        state     <= DRAIN;
                    end else if (take_stall && (stall_count != '1)) begin
                        stall_count <= stall_count + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= HALTED;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// Directed testbench for pl_hazard_ctrl: one instance with forwarding and one
// without (using a 2-bit stall counter so saturation is reachable), both driven
// from the same decode-stage inputs.
module tb_pl_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] id_pc;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic [4:0]  id_dst;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_jump;
    logic        id_undefined_instr;
    logic        ex_branch_taken;

    logic        nop1, pcw1, ifw1, flush1, halted1;
    logic [31:0] epc1;
    logic [15:0] cnt1;
    logic        nop0, pcw0, ifw0, flush0, halted0;
    logic [31:0] epc0;
    logic [1:0]  cnt0;

    int checks = 0;
    int errors = 0;

    pl_hazard_ctrl #(.FORWARDING(1), .DRAIN_CYCLES(3), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_jump(id_jump),
        .id_undefined_instr(id_undefined_instr), .ex_branch_taken(ex_branch_taken),
        .id_nop(nop1), .pc_write(pcw1), .ifid_write(ifw1), .ifid_flush(flush1),
        .halted(halted1), .epc(epc1), .stall_count(cnt1)
    );

    pl_hazard_ctrl #(.FORWARDING(0), .DRAIN_CYCLES(3), .CNT_W(2)) dut0 (
        .clk(clk), .reset(reset), .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_jump(id_jump),
        .id_undefined_instr(id_undefined_instr), .ex_branch_taken(ex_branch_taken),
        .id_nop(nop0), .pc_write(pcw0), .ifid_write(ifw0), .ifid_flush(flush0),
        .halted(halted0), .epc(epc0), .stall_count(cnt0)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one ID-stage vector after a falling edge; it is consumed at the
    // next rising edge, and combinational outputs are settled on return.
    task automatic applyStimulus(input logic [4:0] rs, input logic urs,
                                 input logic [4:0] rt, input logic urt,
                                 input logic [4:0] dst, input logic wr,
                                 input logic mr, input logic jmp,
                                 input logic undef, input logic br,
                                 input logic [31:0] pc);
        @(negedge clk);
        id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
        id_dst = dst; id_reg_write = wr; id_mem_read = mr; id_jump = jmp;
        id_undefined_instr = undef; ex_branch_taken = br; id_pc = pc;
        #1;
    endtask

    task automatic applyIdle();
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset = 1'b1;
        id_rs = 5'd0; id_uses_rs = 1'b0; id_rt = 5'd0; id_uses_rt = 1'b0;
        id_dst = 5'd0; id_reg_write = 1'b0; id_mem_read = 1'b0; id_jump = 1'b0;
        id_undefined_instr = 1'b0; ex_branch_taken = 1'b0; id_pc = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        applyReset();
        $display("[TB] reset state");
        checkOutput("rst_halted", {31'd0, halted1}, 32'd0);
        checkOutput("rst_epc", epc1, 32'd0);
        checkOutput("rst_cnt", {16'd0, cnt1}, 32'd0);
        checkOutput("rst_pcw", {31'd0, pcw1}, 32'd1);
        checkOutput("rst_nop", {31'd0, nop1}, 32'd0);

        $display("[TB] load-use with forwarding");
        applyReset();
        applyStimulus(5'd29, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10);
        checkOutput("lu_lw_nop", {31'd0, nop1}, 32'd0);
        applyStimulus(5'd8, 1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h14);
        checkOutput("lu_stall_nop", {31'd0, nop1}, 32'd1);
        checkOutput("lu_stall_pcw", {31'd0, pcw1}, 32'd0);
        checkOutput("lu_stall_ifw", {31'd0, ifw1}, 32'd0);
        applyStimulus(5'd8, 1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h14);
        checkOutput("lu_after_nop", {31'd0, nop1}, 32'd0);
        checkOutput("lu_after_pcw", {31'd0, pcw1}, 32'd1);
        checkOutput("lu_cnt", {16'd0, cnt1}, 32'd1);

        $display("[TB] non-load RAW");
        applyReset();
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20);
        applyStimulus(5'd8, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h24);
        checkOutput("raw_fwd_nop", {31'd0, nop1}, 32'd0);
        checkOutput("raw_nofwd_nop1", {31'd0, nop0}, 32'd1);
        applyStimulus(5'd8, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h24);
        checkOutput("raw_nofwd_nop2", {31'd0, nop0}, 32'd1);
        checkOutput("raw_nofwd_pcw2", {31'd0, pcw0}, 32'd0);
        applyStimulus(5'd8, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h24);
        checkOutput("raw_nofwd_nop3", {31'd0, nop0}, 32'd0);
        checkOutput("raw_nofwd_cnt", {30'd0, cnt0}, 32'd2);
        checkOutput("raw_fwd_cnt", {16'd0, cnt1}, 32'd0);

        $display("[TB] stall counter saturation");
        applyReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(5'd8, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h30);
        end
        applyIdle();
        checkOutput("sat_cnt", {30'd0, cnt0}, 32'd3);

        $display("[TB] register zero");
        applyReset();
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40);
        applyStimulus(5'd0, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h44);
        checkOutput("zero_fwd_nop", {31'd0, nop1}, 32'd0);
        checkOutput("zero_nofwd_nop", {31'd0, nop0}, 32'd0);

        $display("[TB] branch precedence");
        applyReset();
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h50);
        applyStimulus(5'd8, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
        checkOutput("br_flush", {31'd0, flush1}, 32'd1);
        checkOutput("br_nop", {31'd0, nop1}, 32'd1);
        checkOutput("br_pcw", {31'd0, pcw1}, 32'd1);
        applyIdle();
        checkOutput("br_after_nop", {31'd0, nop1}, 32'd0);
        checkOutput("br_after_epc", epc1, 32'd0);
        checkOutput("br_after_cnt", {16'd0, cnt1}, 32'd0);

        $display("[TB] jump");
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h60);
        checkOutput("jmp_flush", {31'd0, flush1}, 32'd1);
        checkOutput("jmp_pcw", {31'd0, pcw1}, 32'd1);
        checkOutput("jmp_nop", {31'd0, nop1}, 32'd0);

        $display("[TB] trap, drain and halt");
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40);
        checkOutput("trap_nop", {31'd0, nop1}, 32'd1);
        checkOutput("trap_pcw", {31'd0, pcw1}, 32'd0);
        checkOutput("trap_ifw", {31'd0, ifw1}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                          (i == 0) ? 1'b1 : 1'b0, 32'd0);
            checkOutput($sformatf("drain%0d_nop", i), {31'd0, nop1}, 32'd1);
            checkOutput($sformatf("drain%0d_pcw", i), {31'd0, pcw1}, 32'd0);
            checkOutput($sformatf("drain%0d_flush", i), {31'd0, flush1}, 32'd0);
            checkOutput($sformatf("drain%0d_halted", i), {31'd0, halted1}, 32'd0);
            checkOutput($sformatf("drain%0d_epc", i), epc1, 32'h40);
        end
        applyIdle();
        checkOutput("halt1_halted", {31'd0, halted1}, 32'd1);
        checkOutput("halt1_pcw", {31'd0, pcw1}, 32'd0);
        checkOutput("halt1_nop", {31'd0, nop1}, 32'd1);
        applyIdle();
        checkOutput("halt2_halted", {31'd0, halted1}, 32'd1);

        $display("[TB] reset while halted");
        applyReset();
        checkOutput("hrst_halted", {31'd0, halted1}, 32'd0);
        checkOutput("hrst_epc", epc1, 32'd0);
        checkOutput("hrst_cnt", {16'd0, cnt1}, 32'd0);
        checkOutput("hrst_pcw", {31'd0, pcw1}, 32'd1);
        checkOutput("hrst_nop", {31'd0, nop1}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pl_hazard_ctrl.md
Name: pl_hazard_ctrl

Overview:
Pipeline hazard and exception controller for the 5-stage MIPS pipeline. It consumes the decode-stage control outputs (reg_write, mem_read, jump, undefined_instr, destination register) and the EX-stage branch resolution. It produces the `nop` input of the control decoder together with the PC / IF-ID write enables and the IF-ID flush. It shadows the EX and MEM destination state internally. It runs a drain-and-halt sequence on undefined instructions.

Parameters:
FORWARDING, 1, 1 = full EX/MEM forwarding present, so only load-use stalls; 0 = stall on any RAW against EX or MEM.
DRAIN_CYCLES, 3, cycles after the trap for older instructions to retire (EX, MEM, WB).
CNT_W, 16, width of the stall counter.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
id_pc  input  32  PC of the instruction in ID
id_rs  input  5  rs field in ID
id_rt  input  5  rt field in ID
id_uses_rs  input  1  ID instruction reads rs
id_uses_rt  input  1  ID instruction reads rt
id_dst  input  5  ID destination register (after the reg_dst mux)
id_reg_write  input  1  decoder reg_write
id_mem_read  input  1  decoder mem_read
id_jump  input  1  decoder jump
id_undefined_instr  input  1  decoder undefined_instr
ex_branch_taken  input  1  branch in EX resolved taken this cycle
id_nop  output  1  drives decoder nop; bubble injected into ID/EX
pc_write  output  1  PC register enable
ifid_write  output  1  IF/ID register enable
ifid_flush  output  1  clear IF/ID to a bubble on next edge
halted  output  1  core halted on trap
epc  output  32  PC of the trapping instruction
stall_count  output  CNT_W  saturating count of stall cycles

Behaviour:
- Clocking and reset: single clock; all state changes on rising clk. reset is synchronous, active-high.
- Reset values:
  - State = RUN.
  - Shadow registers cleared.
  - epc = 0, stall_count = 0, halted = 0.
- Outputs are combinational from state and inputs. The RUN-state defaults are pc_write = 1, ifid_write = 1, id_nop = 0, ifid_flush = 0.
- Shadow registers:
  - ex_{dst,wr,mr} capture id_{dst,reg_write,mem_read} each cycle. They capture 0 when id_nop = 1.
  - mem_{dst,wr} capture ex_{dst,wr}.
  - Register 0 never matches.
- Hazard detect (haz): the ID instruction reads rs/rt (per uses_*) matching a hazard source.
  - FORWARDING = 1: the only hazard source is ex_dst with ex_wr & ex_mr.
  - FORWARDING = 0: hazard sources are ex_dst with ex_wr, and mem_dst with mem_wr.
- RUN state, priority highest first:
  1. ex_branch_taken: ifid_flush = 1, id_nop = 1, pc_write = 1. Stall and trap in ID are ignored (wrong path).
  2. id_undefined_instr: id_nop = 1, pc_write = 0, ifid_write = 0. epc <= id_pc. Counter <= DRAIN_CYCLES - 1. Next state DRAIN.
  3. haz: id_nop = 1, pc_write = 0, ifid_write = 0. stall_count increments, saturating at all-ones.
  4. id_jump: ifid_flush = 1, pc_write = 1. The jump itself proceeds (id_nop = 0).
- DRAIN state:
  - pc_write = 0, ifid_write = 0, id_nop = 1.
  - The counter decrements; at 0, next state is HALTED.
  - ex_branch_taken is ignored, since no branch can be older than the trap.
- HALTED state:
  - halted = 1, pc_write = 0, ifid_write = 0, id_nop = 1.
  - The core stays here until reset.
- Repeated stalls: a load-use stall lasts exactly 1 cycle, because the bubble clears ex_mr. With FORWARDING = 0, a dependence on EX stalls 2 cycles.
- Reset mid-DRAIN or mid-HALTED returns to RUN with all outputs at reset values on the next cycle.

Test Plan:
- Load-use (FORWARDING = 1): lw $t0 enters EX (ex_dst = 8, mr = 1) while ID has add reading rs = 8 -> exactly 1 cycle of id_nop = 1, pc_write = 0; stall_count = 1; no stall in the next cycle.
- Non-load RAW with FORWARDING = 1: add $8 in EX, ID reads $8 -> no stall. Same case with FORWARDING = 0 -> 2 stall cycles; stall_count = 2.
- $zero: lw $0 in EX, ID reads rs = 0 -> no stall.
- Branch precedence: ex_branch_taken = 1 in the same cycle as id_undefined_instr = 1 and a hazard -> ifid_flush = 1, id_nop = 1, pc_write = 1; state stays RUN; epc unchanged.
- Trap: id_undefined_instr = 1 with id_pc = 0x0000_0040 -> epc = 0x40; id_nop/pc_write hold 1/0 for 3 DRAIN cycles, then halted = 1 and stays high.
- Jump: id_jump = 1 -> ifid_flush = 1, pc_write = 1, id_nop = 0. Then reset asserted while HALTED -> halted = 0, stall_count = 0, epc = 0 on the next edge.
